icache_assoc: RTL

- Parametrised set-associative instruction cache: the next generation of the direct-mapped ICache.
- Sits between the Instruction Unit (fetch requests) and the memory controller (block refills).
- Adds over the previous generation: configurable associativity, a request/ready handshake, an internal refill FSM, victim selection, and flush (fence.i) support.
- Hit latency is 1 cycle; a miss issues one block request and returns the word the cycle after the fill.

---
 rtl/icache_assoc.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin victim selection,
// a single-outstanding-miss refill FSM and fence.i flush.

module icache_assoc_way #(
  parameter int SET_WIDTH = 6,
  parameter int TAG_WIDTH = 7,
  parameter int BLK_BITS  = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [SET_WIDTH-1:0] rd_set,
  input  logic [TAG_WIDTH-1:0] rd_tag,
  output logic                 hit,
  output logic [BLK_BITS-1:0]  rd_blk,
  input  logic [SET_WIDTH-1:0] wr_set,
  output logic                 wr_line_vld,
  input  logic                 wr_en,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic [BLK_BITS-1:0]  wr_blk
);
  localparam int SETS = 2 ** SET_WIDTH;

  logic [SETS-1:0]      vld;
  logic [TAG_WIDTH-1:0] tags [SETS];
  logic [BLK_BITS-1:0]  blks [SETS];

  always_ff @(posedge clk or posedge rst)
    if (rst)        vld <= '0;
    else if (flush) vld <= '0;
    else if (wr_en) vld[wr_set] <= 1'b1;

  // Tag/data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk)
    if (wr_en) begin
      tags[wr_set] <= wr_tag;
      blks[wr_set] <= wr_blk;
    end

  assign hit         = vld[rd_set] && (tags[rd_set] == rd_tag);
  assign rd_blk      = blks[rd_set];
  assign wr_line_vld = vld[wr_set];
endmodule

module icache_assoc #(
  parameter int ADDR_WIDTH  = 17,
  parameter int BLOCK_WIDTH = 4,
  parameter int SET_WIDTH   = 6,
  parameter int WAYS        = 2
) (
  input  logic                              clkIn,
  input  logic                              resetIn,
  input  logic                              flushIn,
  input  logic                              instrInValid,
  input  logic [ADDR_WIDTH-1:0]             instrAddrIn,
  output logic                              instrReady,
  output logic                              instrOutValid,
  output logic [31:0]                       instrOut,
  output logic                              memReqValid,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memReqAddr,
  input  logic                              memDataValid,
  input  logic [(2**BLOCK_WIDTH)*8-1:0]     memDataIn
);
  localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - BLOCK_WIDTH;
  localparam int BLK_BITS  = (2 ** BLOCK_WIDTH) * 8;
  localparam int WI_W      = (BLOCK_WIDTH > 2) ? BLOCK_WIDTH - 2 : 1;
  localparam int PTR_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SETS      = 2 ** SET_WIDTH;
  localparam int TAG_LO    = SET_WIDTH + BLOCK_WIDTH;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]            miss_addr;
  logic                             flush_seen;
  logic [SETS-1:0][PTR_W-1:0]       ptr;
  logic [TAG_WIDTH-1:0]             req_tag, fill_tag;
  logic [SET_WIDTH-1:0]             req_set, fill_set;
  logic [WI_W-1:0]                  req_word, fill_word;
  logic [WAYS-1:0]                  way_hit, way_vld, way_wr;
  logic [WAYS-1:0][BLK_BITS-1:0]    way_blk;
  logic [BLK_BITS-1:0]              hit_blk;
  logic [PTR_W-1:0]                 victim;
  logic                             use_ptr, accept, any_hit, fill, install;
  logic                             unused;

  assign req_tag  = instrAddrIn[ADDR_WIDTH-1:TAG_LO];
  assign req_set  = instrAddrIn[TAG_LO-1:BLOCK_WIDTH];
  assign fill_tag = miss_addr[ADDR_WIDTH-1:TAG_LO];
  assign fill_set = miss_addr[TAG_LO-1:BLOCK_WIDTH];
  assign unused   = &{1'b0, instrAddrIn[1:0], miss_addr[1:0]};

  if (BLOCK_WIDTH > 2) begin : g_word
    assign req_word  = instrAddrIn[BLOCK_WIDTH-1:2];
    assign fill_word = miss_addr[BLOCK_WIDTH-1:2];
  end else begin : g_word1
    assign req_word  = '0;
    assign fill_word = '0;
  end

  assign instrReady = (state == IDLE) && !flushIn;
  assign accept     = instrInValid && instrReady;
  assign any_hit    = |way_hit;
  assign fill       = (state == REFILL) && memDataValid;
  // A flush seen at any point of the refill keeps the line out of the array.
  assign install    = fill && !flushIn && !flush_seen;

  // Lowest invalid way wins; the round-robin pointer only when the set is full.
  always_comb begin
    victim  = ptr[fill_set];
    use_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!way_vld[w]) begin
        victim  = PTR_W'(w);
        use_ptr = 1'b0;
      end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_wr[w] = install && (victim == PTR_W'(w));
    icache_assoc_way #(
      .SET_WIDTH(SET_WIDTH), .TAG_WIDTH(TAG_WIDTH), .BLK_BITS(BLK_BITS)
    ) u_way (
      .clk(clkIn), .rst(resetIn), .flush(flushIn),
      .rd_set(req_set), .rd_tag(req_tag), .hit(way_hit[w]), .rd_blk(way_blk[w]),
      .wr_set(fill_set), .wr_line_vld(way_vld[w]), .wr_en(way_wr[w]),
      .wr_tag(fill_tag), .wr_blk(memDataIn)
    );
  end

  always_comb begin
    hit_blk = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_blk |= way_blk[w];
  end

  always_ff @(posedge clkIn or posedge resetIn)
    if (resetIn) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !any_hit) state_nxt = REFILL;
      REFILL:  if (memDataValid)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge resetIn)
    if (resetIn) ptr <= '0;
    else if (install && use_ptr && (WAYS > 1))
      ptr[fill_set] <= ptr[fill_set] + PTR_W'(1);

  always_ff @(posedge clkIn or posedge resetIn)
    if (resetIn) begin
      instrOutValid <= 1'b0;
      instrOut      <= '0;
      memReqValid   <= 1'b0;
      memReqAddr    <= '0;
      miss_addr     <= '0;
      flush_seen    <= 1'b0;
    end else begin
      instrOutValid <= 1'b0;
      if (accept) begin
        if (any_hit) begin
          instrOutValid <= 1'b1;
          instrOut      <= hit_blk[req_word*32 +: 32];
        end else begin
          miss_addr   <= instrAddrIn;
          memReqValid <= 1'b1;
          memReqAddr  <= instrAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH];
        end
      end
      // Critical word is forwarded from the refill bus, not re-read.
      if (fill) begin
        instrOutValid <= 1'b1;
        instrOut      <= memDataIn[fill_word*32 +: 32];
        memReqValid   <= 1'b0;
      end
      flush_seen <= (state == REFILL) && !fill && (flush_seen || flushIn);
    end
endmodule
